// File: rtl/accum4_pkg.sv
// Shared types and constants for the 4-bit accumulator controller.
// Holds the FSM state encoding, the datapath width and the saturation limits.
package accum4_pkg;

   localparam int unsigned ACC_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ADD  = 2'b01,
      HOLD = 2'b10
   } state_t;

   // Values committed when saturating arithmetic clamps a result
   localparam logic [ACC_W-1:0] SAT_MAX = '1;
   localparam logic [ACC_W-1:0] SAT_MIN = '0;

endpackage

// File: rtl/accum4_ctrl.sv
// Sequential add/subtract wrapper around an external ripple adder.
// Define ACCUM4_SAT_EN for saturating arithmetic; default build wraps around.
module accum4_ctrl
   import accum4_pkg::*;
#(
   parameter int unsigned WIDTH = ACC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sub,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_s,
   input  logic             add_cout,
   output logic [WIDTH-1:0] acc,
   output logic             carry,
   output logic             ovf,
   output logic [3:0]       op_cnt,
   output logic             out_valid,
   input  logic             out_ready
);

   state_t           state, state_nx;
   logic [WIDTH-1:0] op_reg, op_reg_nx, acc_nx;
   logic             op_sub, op_sub_nx;
   logic             carry_nx, ovf_nx, op_ovf;
   logic [3:0]       op_cnt_nx;
   logic             in_ready_nx, out_valid_nx;

   // Adder operands come straight from registered state; subtract is A + ~B + 1
   assign add_a   = acc;
   assign add_b   = op_sub ? ~op_reg : op_reg;
   assign add_cin = op_sub;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      acc_nx    = acc;
      carry_nx  = carry;
      ovf_nx    = ovf;
      op_cnt_nx = op_cnt;
      op_reg_nx = op_reg;
      op_sub_nx = op_sub;
      // Add overflows on carry-out; subtract underflows on a missing carry (borrow)
      op_ovf    = op_sub ? ~add_cout : add_cout;

      if (clr) begin
         state_nx  = IDLE;
         acc_nx    = '0;
         carry_nx  = 1'b0;
         ovf_nx    = 1'b0;
         op_cnt_nx = 4'd0;
         op_reg_nx = '0;
         op_sub_nx = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  op_reg_nx = in_data;
                  op_sub_nx = in_sub;
                  state_nx  = ADD;
               end
            end
            ADD: begin
               acc_nx = add_s;
`ifdef ACCUM4_SAT_EN
               if (op_ovf) acc_nx = op_sub ? WIDTH'(SAT_MIN) : WIDTH'(SAT_MAX);
`endif
               carry_nx  = add_cout;
               ovf_nx    = ovf | op_ovf;
               op_cnt_nx = op_cnt + 4'd1;
               state_nx  = HOLD;
            end
            HOLD: begin
               if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end

      in_ready_nx  = (state_nx == IDLE);
      out_valid_nx = (state_nx == HOLD);
   end

   // Datapath and handshake flags, registered alongside the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         carry     <= 1'b0;
         ovf       <= 1'b0;
         op_cnt    <= 4'd0;
         op_reg    <= '0;
         op_sub    <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         acc       <= acc_nx;
         carry     <= carry_nx;
         ovf       <= ovf_nx;
         op_cnt    <= op_cnt_nx;
         op_reg    <= op_reg_nx;
         op_sub    <= op_sub_nx;
         in_ready  <= in_ready_nx;
         out_valid <= out_valid_nx;
      end
   end

endmodule

// File: tb/tb_accum4_ctrl.sv
// Bench for accum4_ctrl: behavioural adder, arithmetic reference model, scenario tasks.
// Honours ACCUM4_SAT_EN the same way as the design.
module tb_accum4_ctrl;

   logic       clk = 1'b0;
   logic       rst, clr, in_valid, in_sub, out_ready;
   logic [3:0] in_data;
   logic       in_ready, add_cin, add_cout, carry, ovf, out_valid;
   logic [3:0] add_a, add_b, add_s, acc, op_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   int m_acc, m_cnt;
   bit m_carry, m_ovf;

   always #5 clk = ~clk;

   // Stand-in for the external ripple adder
   assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

   accum4_ctrl dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sub(in_sub),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
      .acc(acc), .carry(carry), .ovf(ovf), .op_cnt(op_cnt),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic model_reset();
      m_acc = 0; m_cnt = 0; m_carry = 0; m_ovf = 0;
   endtask

   // Plain integer arithmetic: carry means "no unsigned wrap" for subtract, "wrapped" for add
   task automatic model_op(input int d, input bit s);
      int r;
      if (!s) begin
         r = m_acc + d;
         m_carry = (r > 15);
         if (r > 15) m_ovf = 1;
         m_acc = r % 16;
`ifdef ACCUM4_SAT_EN
         if (r > 15) m_acc = 15;
`endif
      end else begin
         r = m_acc - d;
         m_carry = (r >= 0);
         if (r < 0) m_ovf = 1;
         m_acc = (r + 16) % 16;
`ifdef ACCUM4_SAT_EN
         if (r < 0) m_acc = 0;
`endif
      end
      m_cnt = (m_cnt + 1) % 16;
   endtask

   // One full transaction; caller sits just after a rising edge
   task automatic do_op(input logic [3:0] d, input logic s, input int stall);
      int guard = 0;
      while (in_ready !== 1'b1 && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 20) begin
         n_tests++; n_fail++;
         $display("FAIL op_in_ready_timeout: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1; in_data = d; in_sub = s; out_ready = (stall == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      model_op(int'(d), s);
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc !== 4'(m_acc) || carry !== m_carry ||
          ovf !== m_ovf || op_cnt !== 4'(m_cnt)) begin
         n_fail++;
         $display("FAIL op_result d=%0d sub=%0d: valid=%b rdy=%b acc=%0d carry=%b ovf=%b cnt=%0d required valid=1 rdy=0 acc=%0d carry=%b ovf=%b cnt=%0d",
                  d, s, out_valid, in_ready, acc, carry, ovf, op_cnt, m_acc, m_carry, m_ovf, m_cnt);
      end
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         n_tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc !== 4'(m_acc)) begin
            n_fail++;
            $display("FAIL op_stall cycle %0d: valid=%b rdy=%b acc=%0d required valid=1 rdy=0 acc=%0d",
                     i, out_valid, in_ready, acc, m_acc);
         end
         if (i == stall - 1) out_ready = 1'b1;
      end
      @(posedge clk); #1;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL op_release: rdy=%b valid=%b required rdy=1 valid=0", in_ready, out_valid);
      end
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      model_reset();
   endtask

   task automatic check_reset_outputs(input string tag);
      n_tests++;
      if (acc !== 4'd0 || carry !== 1'b0 || ovf !== 1'b0 || op_cnt !== 4'd0 || out_valid !== 1'b0 ||
          in_ready !== 1'b1 || add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: acc=%0d carry=%b ovf=%b cnt=%0d valid=%b rdy=%b a=%0d b=%0d cin=%b required all 0, rdy=1",
                  tag, acc, carry, ovf, op_cnt, out_valid, in_ready, add_a, add_b, add_cin);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_data = 4'd0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      check_reset_outputs("reset_state");
   endtask

   task automatic test_add_basic();
      do_op(4'd5, 1'b0, 0);
      n_tests++;
      if (acc !== 4'd5) begin n_fail++; $display("FAIL add5: acc=%0d required 5", acc); end
      do_op(4'd3, 1'b0, 0);
      n_tests++;
      if (acc !== 4'd8 || carry !== 1'b0 || ovf !== 1'b0 || op_cnt !== 4'd2) begin
         n_fail++;
         $display("FAIL add3: acc=%0d carry=%b ovf=%b cnt=%0d required 8 0 0 2", acc, carry, ovf, op_cnt);
      end
   endtask

   task automatic test_overflow();
      logic [3:0] exp_a;
      do_clr();
      do_op(4'd12, 1'b0, 0);
      do_op(4'd7, 1'b0, 0);
`ifdef ACCUM4_SAT_EN
      exp_a = 4'd15;
`else
      exp_a = 4'd3;
`endif
      n_tests++;
      if (acc !== exp_a || carry !== 1'b1 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL add_ovf: acc=%0d carry=%b ovf=%b required %0d 1 1", acc, carry, ovf, exp_a);
      end
   endtask

   task automatic test_subtract();
      logic [3:0] exp_s;
      do_clr();
      do_op(4'd2, 1'b0, 0);
      do_op(4'd5, 1'b1, 0);
`ifdef ACCUM4_SAT_EN
      exp_s = 4'd0;
`else
      exp_s = 4'd13;
`endif
      n_tests++;
      if (acc !== exp_s || carry !== 1'b0 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_under: acc=%0d carry=%b ovf=%b required %0d 0 1", acc, carry, ovf, exp_s);
      end
      do_clr();
      do_op(4'd9, 1'b0, 0);
      do_op(4'd4, 1'b1, 0);
      n_tests++;
      if (acc !== 4'd5 || carry !== 1'b1 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_plain: acc=%0d carry=%b ovf=%b required 5 1 0", acc, carry, ovf);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] held;
      do_clr();
      do_op(4'd4, 1'b0, 0);
      in_valid = 1'b1; in_data = 4'd2; in_sub = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      model_op(2, 1'b0);
      held = acc;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i == 4); in_data = 4'd6;
         @(posedge clk); #1;
         n_tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc !== 4'(m_acc) || op_cnt !== 4'(m_cnt)) begin
            n_fail++;
            $display("FAIL backpressure cycle %0d: valid=%b rdy=%b acc=%0d cnt=%0d required 1 0 %0d %0d",
                     i, out_valid, in_ready, acc, op_cnt, m_acc, m_cnt);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc !== held) begin
         n_fail++;
         $display("FAIL backpressure_release: rdy=%b valid=%b acc=%0d required 1 0 %0d", in_ready, out_valid, acc, held);
      end
      // The ignored operand must not have been latched
      do_op(4'd1, 1'b0, 0);
   endtask

   task automatic test_clr_in_add();
      do_clr();
      do_op(4'd7, 1'b0, 0);
      in_valid = 1'b1; in_data = 4'd4; in_sub = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      model_reset();
      check_reset_outputs("clr_in_add");
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc !== 4'd0) begin
         n_fail++;
         $display("FAIL clr_in_add_after: valid=%b rdy=%b acc=%0d required 0 1 0", out_valid, in_ready, acc);
      end
   endtask

   task automatic test_cnt_wrap();
      do_clr();
      for (int i = 1; i <= 17; i++) begin
         do_op(4'd1, 1'b0, 0);
         if (i == 16) begin
            n_tests++;
`ifdef ACCUM4_SAT_EN
            if (ovf !== 1'b1 || op_cnt !== 4'd0 || acc !== 4'd15) begin
`else
            if (ovf !== 1'b1 || op_cnt !== 4'd0 || acc !== 4'd0) begin
`endif
               n_fail++;
               $display("FAIL wrap16: ovf=%b cnt=%0d acc=%0d", ovf, op_cnt, acc);
            end
         end
      end
      n_tests++;
`ifdef ACCUM4_SAT_EN
      if (op_cnt !== 4'd1 || acc !== 4'd15 || ovf !== 1'b1) begin
`else
      if (op_cnt !== 4'd1 || acc !== 4'd1 || ovf !== 1'b1) begin
`endif
         n_fail++;
         $display("FAIL wrap17: cnt=%0d acc=%0d ovf=%b", op_cnt, acc, ovf);
      end
   endtask

   task automatic test_async_rst();
      do_op(4'd3, 1'b0, 0);
      in_valid = 1'b1; in_data = 4'd5; in_sub = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      model_reset();
      check_reset_outputs("async_rst_mid_hold");
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("async_rst_after");
   endtask

   task automatic test_random();
      do_clr();
      for (int i = 0; i < 40; i++) begin
         do_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 9) == 0) do_clr();
      end
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_overflow();
      test_subtract();
      test_backpressure();
      test_clr_in_add();
      test_cnt_wrap();
      test_async_rst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/accum4_ctrl.md
# accum4_ctrl

4-bit accumulator controller that sits directly downstream of the 4-bit ripple adder (`Adder4b`). It drives the adder's A/B/Cin inputs, registers its S/Cout outputs, and feeds S back as the next A operand. Operands arrive over a valid/ready handshake, and results are offered over a second valid/ready handshake. The block is the sequential wrapper that turns the combinational lab adder into a running add/subtract calculator for the board.

## Interface
- `WIDTH`, default 4: datapath width; must match the adder instance.
- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `clr`: input, 1 bit. Synchronous clear of accumulator, flags and FSM.
- `in_valid`: input, 1 bit. Operand offered.
- `in_ready`: output, 1 bit. Block can accept an operand.
- `in_data`: input, WIDTH bits. Operand.
- `in_sub`: input, 1 bit. 1 = subtract operand, 0 = add; sampled with `in_data`.
- `add_a`: output, WIDTH bits. To adder A; always equals `acc`.
- `add_b`: output, WIDTH bits. To adder B; `op_sub ? ~op_reg : op_reg`.
- `add_cin`: output, 1 bit. To adder Cin; equals `op_sub`.
- `add_s`: input, WIDTH bits. From adder S.
- `add_cout`: input, 1 bit. From adder Cout.
- `acc`: output, WIDTH bits. Accumulator value.
- `carry`: output, 1 bit. Cout of the last operation.
- `ovf`: output, 1 bit. Sticky unsigned overflow/underflow flag.
- `op_cnt`: output, 4 bits. Completed operations, modulo 16.
- `out_valid`: output, 1 bit. Result available.
- `out_ready`: input, 1 bit. Consumer takes the result.

## Operation
- FSM states: IDLE, ADD, HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `in_data` into `op_reg` and `in_sub` into `op_sub`, then go to ADD.
- ADD:
  - `in_ready`=0. The adder settles combinationally from `acc`/`op_reg`.
  - At the end of the cycle: `acc`←`add_s`, `carry`←`add_cout`, `op_cnt`←`op_cnt`+1 (wraps 15→0), then go to HOLD.
- HOLD:
  - `out_valid`=1, `in_ready`=0.
  - On `out_ready`: go to IDLE. Otherwise hold indefinitely with all outputs stable.
- Overflow:
  - Add overflows when `add_cout`=1.
  - Subtract underflows when `add_cout`=0 (a borrow).
  - Either condition sets `ovf`. `ovf` clears only on `rst` or `clr`.
- `clr` has priority over all FSM activity. It zeroes `acc`, `carry`, `ovf`, `op_cnt` and `op_reg`, and forces IDLE.
  - `clr` in ADD: no update is committed.
  - `clr` in HOLD: the pending result is discarded.
- `in_valid` while `in_ready`=0 is ignored; the producer must hold its operand.
- Reset values: `acc`=0, `carry`=0, `ovf`=0, `op_cnt`=0, `out_valid`=0, `in_ready`=1, state IDLE. The adder outputs follow: `add_a`=0, `add_b`=0, `add_cin`=0.

## Timing
- Handshake in cycle n → ADD in n+1 → new `acc`/`carry`/`ovf`/`op_cnt` visible from n+2, with `out_valid` high from n+2.
- With `out_ready` tied high: HOLD lasts 1 cycle, `in_ready` returns in n+3, and peak throughput is 1 operation per 3 cycles.
- `out_valid` and `in_ready` are registered-state decodes (glitch-free), never combinational on inputs.
- `rst` asserted mid-operation clears immediately, without waiting for a clock. Deassertion is synchronous to `clk`.
- The adder path is allowed one full cycle (ADD); no multicycle constraint.

## Configuration
- Macro: `ACCUM4_SAT_EN`.
- Defined: saturating arithmetic. An add overflow commits `acc`=all ones (4'hF). A subtract underflow commits `acc`=0. `carry` and `ovf` still update as normal.
- Undefined: wrap-around. `acc`←`add_s` unconditionally.

## Structure
- Shared package `accum4_pkg` holds:
  - the state enumeration (IDLE/ADD/HOLD encoded 2'b00/2'b01/2'b10);
  - the width constant `ACC_W`=4;
  - the saturation limits.
- No sub-module inside the block. The adder stays an external instance, connected at the level above, so the same adder can be tested standalone.

## Test plan
- Reset, then add 5 then add 3 → `acc`=5 then 8; `carry`=0, `ovf`=0, `op_cnt`=2.
- `acc`=12, add 7:
  - without the macro → `acc`=3, `carry`=1, `ovf`=1;
  - with `ACCUM4_SAT_EN` → `acc`=15, `ovf`=1.
- `acc`=2, subtract 5:
  - without the macro → `acc`=13, `carry`=0, `ovf`=1;
  - with the macro → `acc`=0.
  - `acc`=9, subtract 4 → `acc`=5, `carry`=1.
- `out_ready` held low 10 cycles → `out_valid` stays 1, `in_ready` stays 0, and an `in_valid` pulse with 6 is ignored (`acc` unchanged). `in_ready` returns 1 one cycle after `out_ready`.
- `clr` asserted in ADD with pending add of 4 to `acc`=7 → next cycle `acc`=0, `op_cnt`=0, state IDLE, no `out_valid`.
- 17 consecutive adds of 1 from reset → `op_cnt` wraps to 1, `acc`=1, `ovf`=1 (set at the 16th add). Async `rst` pulsed mid-HOLD → all outputs reach reset values before the next edge.
